// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N producers, the arbitrated mux and one consumer.
// The master side drives requests and out_ready; the slave side is the mux.
interface rr_arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated mux: round-robin or fixed-priority grant into a single
// registered output beat that is held until the consumer accepts it.
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = 1
) (
  input logic         clk,
  input logic         rst,
  rr_arb_mux_if.slave bus
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  base;
  logic [SELW-1:0]  win;
  logic [SELW-1:0]  win_nxt;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [N-1:0]     ready;
  logic             any;
  logic             load;
  logic             ov;
  logic [WIDTH-1:0] od;
  logic [WIDTH-1:0] wdata;
  logic [SELW-1:0]  os;

  assign base = (RR != 0) ? ptr : '0;
  assign any  = |bus.in_valid;
  assign load = !ov || bus.out_ready;

  // Rotating a doubled copy puts channel 'base' at bit 0, so the lowest set
  // bit of rot is the first requester at or after the pointer.
  assign dbl = {bus.in_valid, bus.in_valid};
  assign rot = N'(dbl >> base);

  always_comb begin
    int j;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) j = k;
    end
    j = j + int'(base);
    if (j >= N) j = j - N;
    win = SELW'(j);
  end

  assign win_nxt = (win == SELW'(N - 1)) ? '0 : win + 1'b1;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (win == SELW'(i)) wdata = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < N; i++) begin
      ready[i] = !rst && load && any && (win == SELW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ov  <= 1'b0;
      od  <= '0;
      os  <= '0;
      ptr <= '0;
    end else if (load) begin
      if (any) begin
        ov <= 1'b1;
        od <= wdata;
        os <= win;
        if (RR != 0) ptr <= win_nxt;
      end else begin
        ov <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_sel   = os;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a vector table on a 4-channel round-robin
// instance, plus short sequences on a 3-channel RR and a 4-channel fixed-priority one.
module tb_rr_arb_mux;
  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  rr_arb_mux_if #(.WIDTH(32), .N(4)) b4 ();
  rr_arb_mux_if #(.WIDTH(32), .N(3)) b3 ();
  rr_arb_mux_if #(.WIDTH(32), .N(4)) bf ();

  rr_arb_mux #(.WIDTH(32), .N(4), .RR(1)) u_rr4 (.clk(clk), .rst(rst), .bus(b4));
  rr_arb_mux #(.WIDTH(32), .N(3), .RR(1)) u_rr3 (.clk(clk), .rst(rst), .bus(b3));
  rr_arb_mux #(.WIDTH(32), .N(4), .RR(0)) u_fp4 (.clk(clk), .rst(rst), .bus(bf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic        ordy;
    logic [3:0]  ir;
    logic        ov;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [1:0]  ptr;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step3(input logic [2:0] iv, input logic [2:0] ir, input logic [1:0] sel,
                       input logic [31:0] data, input logic [1:0] ptr);
    @(negedge clk);
    b3.in_valid = iv;
    #1 chk("rr3 in_ready", 32'(b3.in_ready), 32'(ir));
    @(posedge clk);
    #1;
    chk("rr3 out_valid", 32'(b3.out_valid), 32'd1);
    chk("rr3 out_sel", 32'(b3.out_sel), 32'(sel));
    chk("rr3 out_data", b3.out_data, data);
    chk("rr3 ptr", 32'(u_rr3.ptr), 32'(ptr));
  endtask

  task automatic stepfp(input logic [3:0] iv, input logic [3:0] ir, input logic [1:0] sel,
                        input logic [31:0] data);
    @(negedge clk);
    bf.in_valid = iv;
    #1 chk("fp in_ready", 32'(bf.in_ready), 32'(ir));
    @(posedge clk);
    #1;
    chk("fp out_valid", 32'(bf.out_valid), 32'd1);
    chk("fp out_sel", 32'(bf.out_sel), 32'(sel));
    chk("fp out_data", bf.out_data, data);
    chk("fp ptr", 32'(u_fp4.ptr), 32'd0);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4.in_data[i*32 +: 32] = 32'hA0 + 32'(i);
      bf.in_data[i*32 +: 32] = 32'hC0 + 32'(i);
    end
    for (int i = 0; i < 3; i++) b3.in_data[i*32 +: 32] = 32'hB0 + 32'(i);
    b4.in_valid = '0; b4.out_ready = 1'b1;
    b3.in_valid = '0; b3.out_ready = 1'b1;
    bf.in_valid = '0; bf.out_ready = 1'b1;

    //            rst   iv       ordy  ir       ov    sel   data    ptr
    tbl[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0,  2'd0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0,  2'd0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0,  2'd0};
    tbl[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0,  2'd0};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0, 2'd1};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1, 2'd2};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2, 2'd3};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3, 2'd0};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0, 2'd1};
    tbl[9]  = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3, 2'd0};
    tbl[10] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0, 2'd1};
    tbl[11] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3, 2'd0};
    tbl[12] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA1, 2'd2};
    tbl[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA1, 2'd2};
    tbl[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA1, 2'd2};
    tbl[15] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hA1, 2'd2};
    tbl[16] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2, 2'd3};
    tbl[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA2, 2'd3};
    tbl[18] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 32'hA2, 2'd3};
    tbl[19] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA2, 2'd3};
    tbl[20] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0,  2'd0};
    tbl[21] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA0, 2'd1};

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst          = tbl[i].rst;
      b4.in_valid  = tbl[i].iv;
      b4.out_ready = tbl[i].ordy;
      #1 chk($sformatf("v%0d in_ready", i), 32'(b4.in_ready), 32'(tbl[i].ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(b4.out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d out_sel", i), 32'(b4.out_sel), 32'(tbl[i].sel));
      chk($sformatf("v%0d out_data", i), b4.out_data, tbl[i].data);
      chk($sformatf("v%0d ptr", i), 32'(u_rr4.ptr), 32'(tbl[i].ptr));
    end
    @(negedge clk);
    b4.in_valid = '0;

    // Three channels: grant to ch2 must wrap the pointer to 0, not 3.
    step3(3'b100, 3'b100, 2'd2, 32'hB2, 2'd0);
    step3(3'b111, 3'b001, 2'd0, 32'hB0, 2'd1);
    step3(3'b110, 3'b010, 2'd1, 32'hB1, 2'd2);
    step3(3'b101, 3'b100, 2'd2, 32'hB2, 2'd0);
    @(negedge clk);
    b3.in_valid = '0;

    // Fixed priority: ch1 starves ch2/ch3 until it drops.
    stepfp(4'b1110, 4'b0010, 2'd1, 32'hC1);
    stepfp(4'b1110, 4'b0010, 2'd1, 32'hC1);
    stepfp(4'b1110, 4'b0010, 2'd1, 32'hC1);
    stepfp(4'b1100, 4'b0100, 2'd2, 32'hC2);
    @(negedge clk);
    bf.in_valid = '0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
